bbox_overlay: RTL
=================

# bbox_overlay

Parametrised multi-box outline overlay on the VGA pixel path, after the frame-buffer read and before the HDMI encoder, in the `pixel_clk` domain. It accepts up to `NUM_BOX` bounding boxes from the detection logic through a load/ack handshake. Loaded boxes are double-buffered so they change only at frame boundaries, and the set expires after `HOLD_FRAMES` frames without a refresh. Each box is drawn with a configurable outline thickness and colour through a fixed 2-cycle pipeline, with the sync signals delayed to match.

## Interface
- `NUM_BOX`, default 4: number of box channels, 1..8.
- `COORD_W`, default 10: coordinate width.
- `COLOR_W`, default 7: per-channel colour width.
- `H_ACTIVE`, default 640: active pixels per line.
- `V_ACTIVE`, default 480: active lines per frame.
- `THICK`, default 2: outline thickness in pixels, 1..8.
- `HOLD_FRAMES`, default 4: frames without a load before the active set clears; 0 means never expire.

Ports:
- `pixel_clk`  in  1: pixel clock; the only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `box_load`  in  1: one-cycle strobe; capture all box inputs.
- `box_valid`  in  `NUM_BOX`: per-box valid.
- `box_min_x`, `box_max_x`, `box_min_y`, `box_max_y`  in  `NUM_BOX*COORD_W` each: packed coordinates; box i occupies bits [i*COORD_W +: COORD_W].
- `box_rgb`  in  `NUM_BOX*3*COLOR_W`: packed {r,g,b} outline colour per box.
- `box_ack`  out  1: one-cycle pulse, 1 cycle after `box_load`.
- `overrun`  out  1: sticky; a load overwrote a pending set not yet promoted.
- `overrun_clr`  in  1: clears `overrun`.
- `draw_x`, `draw_y`  in  `COORD_W`: current pixel position.
- `hs_i`, `vs_i`  in  1: active-low syncs.
- `vde_i`  in  1: active video.
- `r_i`, `g_i`, `b_i`  in  `COLOR_W`: source pixel.
- `hs_o`, `vs_o`, `vde_o`  out  1: syncs delayed 2 cycles.
- `r_o`, `g_o`, `b_o`  out  `COLOR_W`: composited pixel.
- `boxes_live`  out  `NUM_BOX`: active-set valid bits.

## Operation
- Pending set: on `box_load`, all inputs are registered into the pending set and `pend_full` is set. If `pend_full` is already 1, the pending set is overwritten and `overrun` is set.
- Frame boundary: the falling edge of `vs_i`, detected with a registered copy of `vs_i`.
- At the boundary with `pend_full` = 1: pending is copied to active, `pend_full` clears, and `stale_cnt` resets to 0.
- At the boundary with `pend_full` = 0: `stale_cnt` increments, saturating. When `HOLD_FRAMES` != 0 and `stale_cnt` reaches `HOLD_FRAMES`, all active valid bits clear.
- `box_load` coincident with the boundary: the new inputs go straight to active (bypass), `pend_full` stays 0, and `stale_cnt` resets to 0.
- Per-box qualification at promotion: the box is invalid if min_x > max_x, min_y > max_y, min_x >= `H_ACTIVE`, or min_y >= `V_ACTIVE`. min == max is legal and draws a 1-pixel line.
- Hit test, box i, with all differences computed at `COORD_W`+1 bits unsigned:
  - Inside: min_x <= x <= max_x and min_y <= y <= max_y.
  - Outline: inside and (x-min_x < `THICK`, or max_x-x < `THICK`, or y-min_y < `THICK`, or max_y-y < `THICK`).
- Priority: the lowest-index hitting box wins.
- Output: the winning box colour when outline hit and `vde` = 1; otherwise the source pixel. While `vde` = 0, rgb outputs are 0.
- `overrun_clr` and a new overrun in the same cycle leave `overrun` = 1.

## Timing
- Stage 1: register inputs and per-box, per-edge compare flags.
- Stage 2: priority mux and output register.
- Latency: 2 cycles for pixel, sync and `vde`, fixed and with no bubbles.
- Active-set changes take effect from the first pixel following the boundary cycle, so the set never changes mid-frame.
- Reset values:
  - `hs_o` = `vs_o` = 1; `vde_o` = 0; rgb outputs = 0.
  - `box_ack` = 0; `overrun` = 0; `boxes_live` = 0.
  - `pend_full` = 0; `stale_cnt` = 0.
- Reset asserted mid-frame: outputs return to the reset values immediately and the active set is cleared.

## Configuration
- `BBOX_OVERLAY_FILL_EN` defined: box interiors that are not outline pixels output (src + box colour) >> 1 per channel, computed at `COLOR_W`+1 bits and truncated; priority follows the same lowest-index rule. Latency is unchanged.
- Not defined: interiors pass the source pixel unchanged, and no fill logic is synthesised.

## Test plan
- Load box0 = (100,200,50,150), colour 7F/00/00, `THICK`=2, then one frame boundary → pixels (100,50), (101,120) and (200,150) are red; (102,52) is the source; (99,50) is the source; output is 2 cycles after input.
- Load twice before a boundary → `overrun` = 1 and the second set is displayed; `overrun_clr` returns `overrun` to 0.
- `box_load` in the exact boundary cycle → the new box is visible in the first active line of that frame and `box_ack` pulses once.
- `HOLD_FRAMES`=4 with no loads → boxes are drawn for frames 1-3 after promotion; `boxes_live` = 0 at the 4th boundary.
- Box0 and box1 overlapping, plus a box with min_x=300 > max_x=200 → the overlap shows box0 colour, and the invalid box has `boxes_live` bit 0 and never draws.
- Assert `reset_n` low mid-line → `hs_o`=1, `vde_o`=0, rgb 0 within the same cycle; after release, no boxes are drawn until a new load.

Source files
------------

// File: rtl/bbox_overlay.sv
// Multi-box outline overlay on the pixel path; double-buffered box set, 2-cycle latency.
// Define BBOX_OVERLAY_FILL_EN to blend box interiors with the box colour.
module bbox_overlay #(
    parameter int NUM_BOX     = 4,
    parameter int COORD_W     = 10,
    parameter int COLOR_W     = 7,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int THICK       = 2,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                           pixel_clk,
    input  logic                           reset_n,
    input  logic                           box_load,
    input  logic [NUM_BOX-1:0]             box_valid,
    input  logic [NUM_BOX*COORD_W-1:0]     box_min_x,
    input  logic [NUM_BOX*COORD_W-1:0]     box_max_x,
    input  logic [NUM_BOX*COORD_W-1:0]     box_min_y,
    input  logic [NUM_BOX*COORD_W-1:0]     box_max_y,
    input  logic [NUM_BOX*3*COLOR_W-1:0]   box_rgb,
    output logic                           box_ack,
    output logic                           overrun,
    input  logic                           overrun_clr,
    input  logic [COORD_W-1:0]             draw_x,
    input  logic [COORD_W-1:0]             draw_y,
    input  logic                           hs_i,
    input  logic                           vs_i,
    input  logic                           vde_i,
    input  logic [COLOR_W-1:0]             r_i,
    input  logic [COLOR_W-1:0]             g_i,
    input  logic [COLOR_W-1:0]             b_i,
    output logic                           hs_o,
    output logic                           vs_o,
    output logic                           vde_o,
    output logic [COLOR_W-1:0]             r_o,
    output logic [COLOR_W-1:0]             g_o,
    output logic [COLOR_W-1:0]             b_o,
    output logic [NUM_BOX-1:0]             boxes_live
);

    localparam int CW   = COORD_W;
    localparam int KW   = 3 * COLOR_W;
    localparam int XW   = NUM_BOX * CW;
    localparam int PW   = NUM_BOX * KW;
    localparam int SMAX = (HOLD_FRAMES == 0) ? 1 : HOLD_FRAMES;
    localparam int SW   = $clog2(SMAX + 1);
    localparam logic [CW:0] THK = (CW + 1)'(THICK);

    logic              vs_prev_q;
    logic              ack_q;
    logic              overrun_q, overrun_d, overrun_set;
    logic              pend_full_q, pend_full_d;
    logic [SW-1:0]     stale_q, stale_d, stale_inc;
    logic [NUM_BOX-1:0] pend_v_q, act_v_q, act_v_d, qual_v;
    logic [XW-1:0]     pend_x0_q, pend_x1_q, pend_y0_q, pend_y1_q;
    logic [XW-1:0]     act_x0_q, act_x1_q, act_y0_q, act_y1_q;
    logic [PW-1:0]     pend_rgb_q, act_rgb_q;
    logic [NUM_BOX-1:0] src_v;
    logic [XW-1:0]     src_x0, src_x1, src_y0, src_y1;
    logic [PW-1:0]     src_rgb;
    logic              boundary, bypass, promote, pend_we;

    assign boundary = vs_prev_q & ~vs_i;
    assign bypass   = box_load & boundary;
    assign promote  = boundary & (box_load | pend_full_q);
    assign pend_we  = box_load & ~boundary;

    // A load landing on the boundary skips the pending buffer entirely
    assign src_v   = bypass ? box_valid : pend_v_q;
    assign src_x0  = bypass ? box_min_x : pend_x0_q;
    assign src_x1  = bypass ? box_max_x : pend_x1_q;
    assign src_y0  = bypass ? box_min_y : pend_y0_q;
    assign src_y1  = bypass ? box_max_y : pend_y1_q;
    assign src_rgb = bypass ? box_rgb   : pend_rgb_q;

    always_comb begin
        qual_v = '0;
        for (int i = 0; i < NUM_BOX; i++) begin
            qual_v[i] = src_v[i]
                && (src_x0[i*CW +: CW] <= src_x1[i*CW +: CW])
                && (src_y0[i*CW +: CW] <= src_y1[i*CW +: CW])
                && (32'(src_x0[i*CW +: CW]) < H_ACTIVE)
                && (32'(src_y0[i*CW +: CW]) < V_ACTIVE);
        end
    end

    assign stale_inc = (stale_q == SW'(SMAX)) ? stale_q : stale_q + 1'b1;

    always_comb begin
        pend_full_d = pend_full_q;
        stale_d     = stale_q;
        act_v_d     = act_v_q;
        overrun_set = 1'b0;
        if (promote) begin
            act_v_d     = qual_v;
            pend_full_d = 1'b0;
            stale_d     = '0;
        end else if (boundary) begin
            stale_d = stale_inc;
            if (HOLD_FRAMES != 0 && stale_inc >= SW'(SMAX)) begin
                act_v_d = '0;
            end
        end else if (box_load) begin
            pend_full_d = 1'b1;
            overrun_set = pend_full_q;
        end
        overrun_d = (overrun_q & ~overrun_clr) | overrun_set;
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev_q   <= 1'b1;
            ack_q       <= 1'b0;
            overrun_q   <= 1'b0;
            pend_full_q <= 1'b0;
            stale_q     <= '0;
            act_v_q     <= '0;
        end else begin
            vs_prev_q   <= vs_i;
            ack_q       <= box_load;
            overrun_q   <= overrun_d;
            pend_full_q <= pend_full_d;
            stale_q     <= stale_d;
            act_v_q     <= act_v_d;
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_v_q   <= '0;
            pend_x0_q  <= '0;
            pend_x1_q  <= '0;
            pend_y0_q  <= '0;
            pend_y1_q  <= '0;
            pend_rgb_q <= '0;
            act_x0_q   <= '0;
            act_x1_q   <= '0;
            act_y0_q   <= '0;
            act_y1_q   <= '0;
            act_rgb_q  <= '0;
        end else begin
            if (pend_we) begin
                pend_v_q   <= box_valid;
                pend_x0_q  <= box_min_x;
                pend_x1_q  <= box_max_x;
                pend_y0_q  <= box_min_y;
                pend_y1_q  <= box_max_y;
                pend_rgb_q <= box_rgb;
            end
            if (promote) begin
                act_x0_q  <= src_x0;
                act_x1_q  <= src_x1;
                act_y0_q  <= src_y0;
                act_y1_q  <= src_y1;
                act_rgb_q <= src_rgb;
            end
        end
    end

    assign box_ack    = ack_q;
    assign overrun    = overrun_q;
    assign boxes_live = act_v_q;

    logic [NUM_BOX-1:0] inx_d, iny_d, el_d, er_d, et_d, eb_d;
    logic [NUM_BOX-1:0] inx_q, iny_q, el_q, er_q, et_q, eb_q;
    logic [CW:0]        xe, ye;

    assign xe = {1'b0, draw_x};
    assign ye = {1'b0, draw_y};

    always_comb begin
        inx_d = '0;
        iny_d = '0;
        el_d  = '0;
        er_d  = '0;
        et_d  = '0;
        eb_d  = '0;
        for (int i = 0; i < NUM_BOX; i++) begin
            inx_d[i] = act_v_q[i] && (draw_x >= act_x0_q[i*CW +: CW])
                                  && (draw_x <= act_x1_q[i*CW +: CW]);
            iny_d[i] = (draw_y >= act_y0_q[i*CW +: CW])
                    && (draw_y <= act_y1_q[i*CW +: CW]);
            el_d[i]  = (xe - {1'b0, act_x0_q[i*CW +: CW]}) < THK;
            er_d[i]  = ({1'b0, act_x1_q[i*CW +: CW]} - xe) < THK;
            et_d[i]  = (ye - {1'b0, act_y0_q[i*CW +: CW]}) < THK;
            eb_d[i]  = ({1'b0, act_y1_q[i*CW +: CW]} - ye) < THK;
        end
    end

    logic               hs1_q, vs1_q, vde1_q;
    logic [COLOR_W-1:0] r1_q, g1_q, b1_q;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            inx_q  <= '0;
            iny_q  <= '0;
            el_q   <= '0;
            er_q   <= '0;
            et_q   <= '0;
            eb_q   <= '0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            vde1_q <= 1'b0;
            r1_q   <= '0;
            g1_q   <= '0;
            b1_q   <= '0;
        end else begin
            inx_q  <= inx_d;
            iny_q  <= iny_d;
            el_q   <= el_d;
            er_q   <= er_d;
            et_q   <= et_d;
            eb_q   <= eb_d;
            hs1_q  <= hs_i;
            vs1_q  <= vs_i;
            vde1_q <= vde_i;
            r1_q   <= r_i;
            g1_q   <= g_i;
            b1_q   <= b_i;
        end
    end

    logic [NUM_BOX-1:0] ins, outl;
    logic [KW-1:0]      rgb_d;

    assign ins  = inx_q & iny_q;
    assign outl = ins & (el_q | er_q | et_q | eb_q);

`ifdef BBOX_OVERLAY_FILL_EN
    logic               ihit, iout;
    logic [KW-1:0]      icol;
    logic [COLOR_W:0]   sr, sg, sb;

    // Winner is the lowest-index box containing the pixel, outline or not
    always_comb begin
        ihit = 1'b0;
        iout = 1'b0;
        icol = '0;
        for (int i = NUM_BOX - 1; i >= 0; i--) begin
            if (ins[i]) begin
                ihit = 1'b1;
                iout = outl[i];
                icol = act_rgb_q[i*KW +: KW];
            end
        end
        sr = {1'b0, r1_q} + {1'b0, icol[2*COLOR_W +: COLOR_W]};
        sg = {1'b0, g1_q} + {1'b0, icol[COLOR_W +: COLOR_W]};
        sb = {1'b0, b1_q} + {1'b0, icol[0 +: COLOR_W]};
        if (!vde1_q) begin
            rgb_d = '0;
        end else if (ihit && iout) begin
            rgb_d = icol;
        end else if (ihit) begin
            rgb_d = {sr[COLOR_W:1], sg[COLOR_W:1], sb[COLOR_W:1]};
        end else begin
            rgb_d = {r1_q, g1_q, b1_q};
        end
    end
`else
    logic          ohit;
    logic [KW-1:0] ocol;

    always_comb begin
        ohit = 1'b0;
        ocol = '0;
        for (int i = NUM_BOX - 1; i >= 0; i--) begin
            if (outl[i]) begin
                ohit = 1'b1;
                ocol = act_rgb_q[i*KW +: KW];
            end
        end
        if (!vde1_q) begin
            rgb_d = '0;
        end else if (ohit) begin
            rgb_d = ocol;
        end else begin
            rgb_d = {r1_q, g1_q, b1_q};
        end
    end
`endif

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_o  <= 1'b1;
            vs_o  <= 1'b1;
            vde_o <= 1'b0;
            r_o   <= '0;
            g_o   <= '0;
            b_o   <= '0;
        end else begin
            hs_o  <= hs1_q;
            vs_o  <= vs1_q;
            vde_o <= vde1_q;
            r_o   <= rgb_d[2*COLOR_W +: COLOR_W];
            g_o   <= rgb_d[COLOR_W +: COLOR_W];
            b_o   <= rgb_d[0 +: COLOR_W];
        end
    end

endmodule
